// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: FSM state encoding, MemSize codes and lane helpers
// shared by mem_stage and load_align. No ports.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  function automatic logic [3:0] byte_en(
    input logic [1:0] size,
    input logic [1:0] a
  );
    unique case (size)
      SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: byte_en = 4'b0001 << a;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    unique case (size)
      SZ_HALF: misaligned = a[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] store_data(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    unique case (size)
      SZ_HALF: store_data = {2{d[15:0]}};
      SZ_BYTE: store_data = {4{d[7:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed lane of a read word and extends it.
// Ports: rdata, addr_lo, size, is_signed in; data out (combinational).
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (addr_lo)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (size)
      SZ_BYTE: data = {{24{is_signed & b[7]}}, b};
      SZ_HALF: data = {{16{is_signed & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with IDLE/REQ/DONE data-memory FSM.
// Ports: EX/MEM inputs, DMem bus, MEM/WB outputs, Stall/AlignErr/BusErr.
// Optional REQ timeout with BusErr_out: define MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk_in,
  input  logic        Rst,
  input  logic        Valid_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  MemSize_in,
  input  logic        MemSigned_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] WriteData_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        JR_in,
  input  logic        j_and_jal_in,
  input  logic [4:0]  mux2_result_in,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemBe,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        JR_out,
  output logic        j_and_jal_out,
  output logic [4:0]  mux2_result_out,
  output logic        Stall_out,
  output logic        AlignErr_out,
  output logic        BusErr_out
);

  state_t      state;
  logic        req_q;
  logic        bus_err_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data;
  logic        mem_op;
  logic        mis;
  logic        start;
  logic        to_hit;

  assign mem_op = Valid_in & (MemRead_in | MemWrite_in);
  assign mis    = misaligned(MemSize_in, ALUResult_in[1:0]);
  assign start  = mem_op & ~mis;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk_in or negedge Rst) begin
    if (!Rst)
      to_cnt <= '0;
    else if (state == S_REQ && !DMemAck && !to_hit)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end
`else
  // REQ waits for the ack forever in this build
  assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge Clk_in or negedge Rst) begin
    if (!Rst) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (DMemAck) begin
            rdata_q <= DMemRData;
            req_q   <= 1'b0;
            state   <= S_DONE;
          end else if (to_hit) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  load_align u_align (
    .rdata     (rdata_q),
    .addr_lo   (ALUResult_in[1:0]),
    .size      (MemSize_in),
    .is_signed (MemSigned_in),
    .data      (load_data)
  );

  assign DMemReq   = req_q;
  assign DMemWe    = req_q & MemWrite_in;
  assign DMemAddr  = {ALUResult_in[31:2], 2'b00};
  assign DMemBe    = byte_en(MemSize_in, ALUResult_in[1:0]);
  assign DMemWData = store_data(MemSize_in, WriteData_in);

  // stall starts in the issuing cycle, before the FSM leaves IDLE
  assign Stall_out = (state == S_IDLE && start) || (state == S_REQ);

  assign AlignErr_out = mem_op & mis;
  assign BusErr_out   = bus_err_q;

  assign ReadData_out    = bus_err_q ? 32'h0 : load_data;
  assign ALUResult_out   = ALUResult_in;
  assign RegWrite_out    = Valid_in & RegWrite_in
                         & ~AlignErr_out & ~bus_err_q;
  assign MemtoReg_out    = MemtoReg_in;
  assign JR_out          = JR_in;
  assign j_and_jal_out   = j_and_jal_in;
  assign mux2_result_out = mux2_result_in;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage against a timeline model.
// Directed cases pin lw/lb/lbu/sh, misalignment, reset and timeout.
module tb_mem_stage;

  localparam int TO = 4;

  typedef struct packed {
    logic        v, rd, wr, sg, rw, m2r, jr, jal;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic [4:0]  dst;
  } ins_t;

  typedef struct packed {
    logic        stall, req, we, align, bus, rw, m2r, jr, jal;
    logic [4:0]  dst;
    logic [31:0] alu, addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rd_chk;
    logic [31:0] rd;
  } exp_t;

  logic        Clk_in = 1'b0;
  logic        Rst;
  logic        Valid_in, MemRead_in, MemWrite_in, MemSigned_in;
  logic [1:0]  MemSize_in;
  logic [31:0] ALUResult_in, WriteData_in;
  logic        RegWrite_in, MemtoReg_in, JR_in, j_and_jal_in;
  logic [4:0]  mux2_result_in;
  logic        DMemReq, DMemWe, DMemAck;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemBe;
  logic [31:0] ReadData_out, ALUResult_out;
  logic        RegWrite_out, MemtoReg_out, JR_out, j_and_jal_out;
  logic [4:0]  mux2_result_out;
  logic        Stall_out, AlignErr_out, BusErr_out;

  int passed = 0;
  int total  = 0;
  int stall_cnt = 0;
  int bus_cnt = 0;
  logic        chk_en = 1'b0;
  exp_t        ex;
  logic [31:0] cap_rd, cap_wd;
  logic [3:0]  cap_be;
  logic        cap_we;

  always #5 Clk_in = ~Clk_in;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk_in(Clk_in), .Rst(Rst), .Valid_in(Valid_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemSize_in(MemSize_in), .MemSigned_in(MemSigned_in),
    .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .JR_in(JR_in), .j_and_jal_in(j_and_jal_in),
    .mux2_result_in(mux2_result_in),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemBe(DMemBe), .DMemWData(DMemWData),
    .DMemRData(DMemRData), .DMemAck(DMemAck),
    .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .JR_out(JR_out), .j_and_jal_out(j_and_jal_out),
    .mux2_result_out(mux2_result_out), .Stall_out(Stall_out),
    .AlignErr_out(AlignErr_out), .BusErr_out(BusErr_out)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, want);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz,
                                 input logic [31:0] a);
    int nb;
    nb = nbytes(sz);
    return (int'(a[1:0]) % nb) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz,
                                      input logic [31:0] a);
    int nb;
    int lane;
    nb = nbytes(sz);
    lane = int'(a[1:0]) & ~(nb - 1);
    return 4'((32'd1 << nb) - 1) << lane;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz,
                                       input logic [31:0] d);
    case (nbytes(sz))
      1: return 32'(d[7:0]) * 32'h0101_0101;
      2: return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] r,
    input logic [1:0] sz, input logic [31:0] a, input logic sg);
    int nb;
    int sh;
    logic [63:0] mask;
    logic [63:0] v;
    nb = nbytes(sz);
    sh = 8 * (int'(a[1:0]) & ~(nb - 1));
    v = {32'h0, r} >> sh;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = v & mask;
    if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic exp_t mk_exp(input ins_t i);
    exp_t e;
    e = '0;
    e.align = i.v & (i.rd | i.wr) & m_mis(i.sz, i.a);
    e.rw    = i.v & i.rw & ~e.align;
    e.m2r   = i.m2r;
    e.jr    = i.jr;
    e.jal   = i.jal;
    e.dst   = i.dst;
    e.alu   = i.a;
    e.addr  = i.a & ~32'd3;
    e.be    = m_be(i.sz, i.a);
    e.wd    = m_wd(i.sz, i.wd);
    return e;
  endfunction

  task automatic apply(input ins_t i);
    Valid_in       = i.v;
    MemRead_in     = i.rd;
    MemWrite_in    = i.wr;
    MemSize_in     = i.sz;
    MemSigned_in   = i.sg;
    ALUResult_in   = i.a;
    WriteData_in   = i.wd;
    RegWrite_in    = i.rw;
    MemtoReg_in    = i.m2r;
    JR_in          = i.jr;
    j_and_jal_in   = i.jal;
    mux2_result_in = i.dst;
  endtask

  task automatic step();
    @(posedge Clk_in);
    #1;
  endtask

  // k = REQ cycle carrying the ack; k = 0 means no ack at all
  task automatic run_instr(input ins_t i, input int k,
                           input logic [31:0] rdv);
    exp_t e;
    int n;
    apply(i);
    e = mk_exp(i);
    chk_en = 1'b1;
    DMemRData = $urandom;
    DMemAck = 1'($urandom_range(1));
    if (!(i.v && (i.rd || i.wr) && !m_mis(i.sz, i.a))) begin
      ex = e;
      step();
      return;
    end
    e.stall = 1'b1;
    ex = e;
    step();
    n = (k == 0) ? TO : k;
    for (int j = 1; j <= n; j++) begin
      e.req = 1'b1;
      e.we  = i.wr;
      ex = e;
      DMemAck   = (k != 0 && j == k);
      DMemRData = DMemAck ? rdv : $urandom;
      step();
    end
    e.stall = 1'b0;
    e.req   = 1'b0;
    e.we    = 1'b0;
    if (k == 0) begin
      e.bus    = 1'b1;
      e.rw     = 1'b0;
      e.rd_chk = 1'b1;
      e.rd     = 32'h0;
    end else begin
      e.rd_chk = i.rd;
      e.rd     = m_load(rdv, i.sz, i.a, i.sg);
    end
    ex = e;
    DMemAck = 1'($urandom_range(1));
    DMemRData = $urandom;
    step();
  endtask

  function automatic ins_t rnd_ins();
    ins_t r;
    int t;
    r = '0;
    r.v   = ($urandom_range(9) != 0);
    t     = $urandom_range(2);
    r.rd  = (t == 0);
    r.wr  = (t == 1);
    r.sz  = 2'($urandom_range(3));
    r.sg  = 1'($urandom_range(1));
    r.a   = $urandom;
    if ($urandom_range(3) != 0)
      r.a = r.a & ~32'(nbytes(r.sz) - 1);
    r.wd  = $urandom;
    r.rw  = 1'($urandom_range(1));
    r.m2r = 1'($urandom_range(1));
    r.jr  = 1'($urandom_range(1));
    r.jal = 1'($urandom_range(1));
    r.dst = 5'($urandom_range(31));
    return r;
  endfunction

  always @(negedge Clk_in) begin
    if (chk_en) begin
      chk("stall", Stall_out, ex.stall);
      chk("dmemreq", DMemReq, ex.req);
      chk("dmemwe", DMemWe, ex.we);
      chk("alignerr", AlignErr_out, ex.align);
      chk("buserr", BusErr_out, ex.bus);
      chk("regwrite", RegWrite_out, ex.rw);
      chk("memtoreg", MemtoReg_out, ex.m2r);
      chk("jr", JR_out, ex.jr);
      chk("jal", j_and_jal_out, ex.jal);
      chk("dst", mux2_result_out, ex.dst);
      chk("aluout", ALUResult_out, ex.alu);
      chk("addr", DMemAddr, ex.addr);
      chk("be", DMemBe, ex.be);
      chk("wdata", DMemWData, ex.wd);
      if (ex.rd_chk) begin
        chk("rdata", ReadData_out, ex.rd);
        cap_rd = ReadData_out;
      end
      if (ex.req) begin
        cap_be = DMemBe;
        cap_wd = DMemWData;
        cap_we = DMemWe;
      end
      if (Stall_out) stall_cnt++;
      if (BusErr_out) bus_cnt++;
    end
  end

  initial begin
    ins_t i;
    ins_t nop;
    nop = '0;
    Rst = 1'b0;
    apply(nop);
    DMemAck = 1'b0;
    DMemRData = 32'h0;
    #3;
    chk("rst_dmemreq", DMemReq, 1'b0);
    chk("rst_stall", Stall_out, 1'b0);
    chk("rst_buserr", BusErr_out, 1'b0);
    chk("rst_rdreg", ReadData_out, 32'h0);
    repeat (2) step();
    Rst = 1'b1;
    step();

    i = '0;
    i.v = 1; i.rd = 1; i.rw = 1; i.m2r = 1; i.dst = 5'd7;
    i.sz = 2'b00; i.a = 32'h100;
    stall_cnt = 0;
    run_instr(i, 3, 32'hDEAD_BEEF);
    chk("lw_stall_cycles", stall_cnt, 4);
    chk("lw_rdata", cap_rd, 32'hDEAD_BEEF);

    i.sz = 2'b10; i.sg = 1; i.a = 32'h103;
    run_instr(i, 1, 32'h80FF_FFFF);
    chk("lb_be", cap_be, 4'b1000);
    chk("lb_rdata", cap_rd, 32'hFFFF_FF80);
    i.sg = 0;
    run_instr(i, 2, 32'h80FF_FFFF);
    chk("lbu_rdata", cap_rd, 32'h0000_0080);

    i = '0;
    i.v = 1; i.wr = 1; i.sz = 2'b01; i.a = 32'h102;
    i.wd = 32'h1234_ABCD;
    run_instr(i, 2, 32'h0);
    chk("sh_be", cap_be, 4'b1100);
    chk("sh_wdata", cap_wd, 32'hABCD_ABCD);
    chk("sh_we", cap_we, 1'b1);

    i = '0;
    i.v = 1; i.rd = 1; i.rw = 1; i.a = 32'h101;
    apply(i);
    ex = mk_exp(i);
    DMemAck = 1'b0;
    #2;
    chk("mis_align", AlignErr_out, 1'b1);
    chk("mis_req", DMemReq, 1'b0);
    chk("mis_regwrite", RegWrite_out, 1'b0);
    chk("mis_stall", Stall_out, 1'b0);
    step();

    i.a = 32'h200;
    apply(i);
    ex = mk_exp(i);
    ex.stall = 1'b1;
    step();
    ex.req = 1'b1;
    step();
    chk_en = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    chk("rst_in_req_dmemreq", DMemReq, 1'b0);
    chk("rst_in_req_we", DMemWe, 1'b0);
    apply(nop);
    #1;
    chk("rst_in_req_stall", Stall_out, 1'b0);
    step();
    Rst = 1'b1;
    apply(nop);
    DMemAck = 1'b1;
    DMemRData = 32'h1111_2222;
    ex = mk_exp(nop);
    chk_en = 1'b1;
    step();
    chk("late_ack_req", DMemReq, 1'b0);
    DMemAck = 1'b0;
    step();
    chk("late_ack_stall", Stall_out, 1'b0);

`ifdef MEM_TIMEOUT_EN
    i = '0;
    i.v = 1; i.rd = 1; i.rw = 1; i.a = 32'h300;
    bus_cnt = 0;
    run_instr(i, 0, 32'h0);
    chk("timeout_pulses", bus_cnt, 1);
`endif

    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(1, 3);
`ifdef MEM_TIMEOUT_EN
      if ($urandom_range(7) == 0) k = 0;
`endif
      run_instr(rnd_ins(), k, $urandom);
    end
    chk_en = 1'b0;

`ifndef MEM_TIMEOUT_EN
    chk("buserr_never", bus_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
